pmp_arbiter: RTL and testbench
==============================

# pmp_arbiter

Shares one `pmpchecker` instance between the instruction-fetch (I) and load/store (D) requesters. It arbitrates round-robin and latches the winning request into a holding register, from which it drives the checker. It registers the selected fault bit and returns it to the winner over a valid/ready handshake. It sits in the MMU between the IFU/LSU physical-address outputs and the single PMP datapath, replacing per-port checker copies on area-constrained configurations.

## Interface
- `PA_BITS`, default 56: physical address width; must match the checker instance.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `IReqValid` in 1: I requester has an address to check.
- `IReqReady` out 1: I request accepted this cycle.
- `IAdr` in PA_BITS: I physical address.
- `ISize` in 2: I access size.
- `DReqValid` in 1: D requester has an address to check.
- `DReqReady` out 1: D request accepted this cycle.
- `DAdr` in PA_BITS: D physical address.
- `DSize` in 2: D access size.
- `DWrite` in 1: 1 = store/AMO, 0 = load.
- `PrivilegeModeW` in 2: current privilege; sampled at accept.
- `Flush` in 1: abort any in-flight check.
- `RespValid` out 1: result available.
- `RespReady` in 1: requester consumes the result.
- `RespId` out 1: owner of the result; 0 = I, 1 = D.
- `RespFault` out 1: access fault for the owner.
- `ChkAdr` out PA_BITS: address driven to the checker.
- `ChkSize` out 2: size driven to the checker.
- `ChkPriv` out 2: privilege driven to the checker.
- `ChkExecute`, `ChkRead`, `ChkWrite` out 1 each: access strobes to the checker.
- `ChkInstrFault`, `ChkLoadFault`, `ChkStoreFault` in 1 each: checker fault outputs.

## Operation
- FSM states: IDLE, CHECK, RESP. Reset state is IDLE.
- **IDLE**
  - When `Flush`=0 and at least one valid is high, grant one requester.
  - If both are valid, grant the requester not granted last. `LastGrant` resets to I, so D wins the first tie.
  - Assert the granted ready for exactly that cycle.
  - Latch the address, size, `PrivilegeModeW`, id and `DWrite` into the holding registers. Update `LastGrant`. Go to CHECK.
  - If `Flush`=1, both readies stay 0 and the FSM stays in IDLE.
- **CHECK**
  - `ChkAdr`, `ChkSize` and `ChkPriv` come from the holding registers.
  - Exactly one strobe is high:
    - I: `ChkExecute`.
    - D with `DWrite`=1: `ChkWrite`.
    - D with `DWrite`=0: `ChkRead`.
  - Register `RespFault` from the matching checker fault: I → InstrFault, D-write → StoreFault, D-read → LoadFault.
  - Go to RESP unless `Flush`=1, in which case go to IDLE.
- **RESP**
  - `RespValid`=1. `RespId` and `RespFault` are held stable.
  - On `RespReady`=1, go to IDLE. Otherwise hold.
  - `Flush`=1 goes to IDLE and drops the result, even if `RespReady`=1 in the same cycle; the response is not consumed.
- Strobes are all 0 outside CHECK, so the checker never reports a spurious fault. `ChkAdr`, `ChkSize` and `ChkPriv` always reflect the holding registers.
- Readies are 0 outside IDLE. There is no accept in the RESP→IDLE cycle.
- A requester may drop valid before it is granted; nothing is latched for it.

## Timing
- Reset values:
  - `IReqReady`, `DReqReady`, `RespValid`, `RespId`, `RespFault` = 0.
  - All `Chk*` outputs = 0.
  - Holding registers = 0; `LastGrant` = I.
- Readies are combinational from state, valids, `Flush` and `LastGrant`.
- Latency: accept in cycle N, CHECK in N+1, `RespValid` high from N+2.
- Best-case throughput is one check every 3 cycles.
- Fairness: with both requesters continuously valid, grants alternate D, I, D, I…
- `reset_n` asserted in any state forces IDLE and the reset values immediately, independent of `clk`. The in-flight request is lost.
- Privilege changes after accept do not affect the in-flight check.

## Test plan
- **Single I request**: reset, then `IReqValid`=1, `IAdr`=0x8000_0000, `ISize`=2, checker returns InstrFault=1 → `IReqReady`=1 in cycle 0, `ChkExecute`=1 only in cycle 1, `RespValid`=1 with `RespId`=0 and `RespFault`=1 from cycle 2.
- **Both valid from reset**: both valids held high, `RespReady`=1 → grant order D, I, D; each `RespValid` is 2 cycles after its ready, accepts spaced 3 cycles apart.
- **D store vs load**: D request with `DWrite`=1 and StoreFault=1, LoadFault=0 → `ChkWrite`=1, `RespFault`=1. Repeat with `DWrite`=0 → `ChkRead`=1, `RespFault`=0.
- **Backpressure**: `RespReady`=0 for 5 cycles in RESP → `RespValid`, `RespId` and `RespFault` stable; readies stay 0 while new valids are pending; accept resumes the cycle after IDLE is re-entered.
- **Flush and privilege**:
  - `Flush` in CHECK → next cycle IDLE, `RespValid` never asserts.
  - `Flush` in RESP with `RespReady`=1 → result dropped.
  - `Flush` held in IDLE → no ready.
  - Change `PrivilegeModeW` from 3 to 0 in CHECK → `ChkPriv` remains 3.
- **Async reset**: `reset_n`=0 mid-CHECK, between clock edges → all outputs 0 at once; after release, a fresh request completes normally and D wins the first tie.

Source files
------------

// File: rtl/pmp_arbiter.sv
// Round-robin arbiter sharing one PMP checker between the I and D requesters.
// Each accepted request is held, checked for one cycle, then returned as a response.
module pmp_arbiter #(
  parameter int PA_BITS = 56
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               IReqValid,
  output logic               IReqReady,
  input  logic [PA_BITS-1:0] IAdr,
  input  logic [1:0]         ISize,
  input  logic               DReqValid,
  output logic               DReqReady,
  input  logic [PA_BITS-1:0] DAdr,
  input  logic [1:0]         DSize,
  input  logic               DWrite,
  input  logic [1:0]         PrivilegeModeW,
  input  logic               Flush,
  output logic               RespValid,
  input  logic               RespReady,
  output logic               RespId,
  output logic               RespFault,
  output logic [PA_BITS-1:0] ChkAdr,
  output logic [1:0]         ChkSize,
  output logic [1:0]         ChkPriv,
  output logic               ChkExecute,
  output logic               ChkRead,
  output logic               ChkWrite,
  input  logic               ChkInstrFault,
  input  logic               ChkLoadFault,
  input  logic               ChkStoreFault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e             state_q;
  logic               last_q;
  logic [PA_BITS-1:0] adr_q;
  logic [1:0]         size_q;
  logic [1:0]         priv_q;
  logic               id_q;
  logic               wr_q;
  logic               fault_q;

  logic idle_ok;
  logic gnt_i;
  logic gnt_d;
  logic fault_sel;
  logic in_chk;

  // Readies are held low while reset is asserted.
  assign idle_ok = reset_n & (state_q == IDLE) & ~Flush;
  assign gnt_d   = idle_ok & DReqValid
                 & (~IReqValid | ~last_q);
  assign gnt_i   = idle_ok & IReqValid
                 & (~DReqValid | last_q);

  assign IReqReady = gnt_i;
  assign DReqReady = gnt_d;

  assign in_chk     = (state_q == CHECK);
  assign ChkExecute = in_chk & ~id_q;
  assign ChkWrite   = in_chk & id_q & wr_q;
  assign ChkRead    = in_chk & id_q & ~wr_q;

  assign ChkAdr  = adr_q;
  assign ChkSize = size_q;
  assign ChkPriv = priv_q;

  assign RespValid = (state_q == RESP);
  assign RespId    = id_q;
  assign RespFault = fault_q;

  always_comb begin
    fault_sel = 1'b0;
    unique case (1'b1)
      ~id_q:        fault_sel = ChkInstrFault;
      id_q & wr_q:  fault_sel = ChkStoreFault;
      default:      fault_sel = ChkLoadFault;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      adr_q   <= '0;
      size_q  <= '0;
      priv_q  <= '0;
      id_q    <= 1'b0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_i | gnt_d) begin
            adr_q   <= gnt_d ? DAdr : IAdr;
            size_q  <= gnt_d ? DSize : ISize;
            priv_q  <= PrivilegeModeW;
            id_q    <= gnt_d;
            wr_q    <= gnt_d & DWrite;
            last_q  <= gnt_d;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          fault_q <= fault_sel;
          state_q <= Flush ? IDLE : RESP;
        end
        RESP: begin
          if (Flush | RespReady)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_arbiter.sv
// Randomized and directed bench for pmp_arbiter against a
// transaction-level reference model.
module tb_pmp_arbiter;

  localparam int PA = 56;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          iv, dv, dwr, fl, rr;
  logic [PA-1:0] iadr, dadr;
  logic [1:0]    isz, dsz, priv;
  logic          fi, fld, fst;

  logic          irdy, drdy, rvalid, rid, rfault;
  logic [PA-1:0] cadr;
  logic [1:0]    csz, cpriv;
  logic          cx, cr, cw;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pmp_arbiter #(.PA_BITS(PA)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .IReqValid(iv),
    .IReqReady(irdy),
    .IAdr(iadr),
    .ISize(isz),
    .DReqValid(dv),
    .DReqReady(drdy),
    .DAdr(dadr),
    .DSize(dsz),
    .DWrite(dwr),
    .PrivilegeModeW(priv),
    .Flush(fl),
    .RespValid(rvalid),
    .RespReady(rr),
    .RespId(rid),
    .RespFault(rfault),
    .ChkAdr(cadr),
    .ChkSize(csz),
    .ChkPriv(cpriv),
    .ChkExecute(cx),
    .ChkRead(cr),
    .ChkWrite(cw),
    .ChkInstrFault(fi),
    .ChkLoadFault(fld),
    .ChkStoreFault(fst)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction with an age
  // counted in cycles since its accept.
  typedef struct {
    bit [PA-1:0] adr;
    bit [1:0]    size;
    bit [1:0]    priv;
    bit          is_d;
    bit          wr;
  } txn_t;

  txn_t m_cur;
  bit   m_busy;
  int   m_age;
  bit   m_fault;
  bit   m_last_d;
  int   gnt_q[$];

  task automatic model_reset();
    m_cur    = '{default: '0};
    m_busy   = 0;
    m_age    = 0;
    m_fault  = 0;
    m_last_d = 0;
  endtask

  task automatic step();
    bit want_d, want_i, pick_d, acc;
    bit chk_ph, rsp_ph;
    #1;
    if (!reset_n) model_reset();
    acc    = reset_n && !m_busy && !fl && (iv || dv);
    pick_d = dv && (!iv || !m_last_d);
    want_d = acc && pick_d;
    want_i = acc && !pick_d;
    chk_ph = m_busy && m_age == 1;
    rsp_ph = m_busy && m_age >= 2;

    check("irdy", irdy, want_i);
    check("drdy", drdy, want_d);
    check("rvalid", rvalid, rsp_ph);
    check("rid", rid, m_cur.is_d);
    check("rfault", rfault, m_fault);
    check("chkadr", cadr, m_cur.adr);
    check("chksize", csz, m_cur.size);
    check("chkpriv", cpriv, m_cur.priv);
    check("chkx", cx, chk_ph && !m_cur.is_d);
    check("chkr", cr, chk_ph && m_cur.is_d && !m_cur.wr);
    check("chkw", cw, chk_ph && m_cur.is_d && m_cur.wr);

    if (irdy) gnt_q.push_back(0);
    if (drdy) gnt_q.push_back(1);

    @(posedge clk);
    if (reset_n) begin
      if (!m_busy) begin
        if (acc) begin
          m_cur.adr  = pick_d ? dadr : iadr;
          m_cur.size = pick_d ? dsz : isz;
          m_cur.priv = priv;
          m_cur.is_d = pick_d;
          m_cur.wr   = pick_d && dwr;
          m_last_d   = pick_d;
          m_busy     = 1;
          m_age      = 1;
        end
      end else if (m_age == 1) begin
        if (!m_cur.is_d)    m_fault = fi;
        else if (m_cur.wr)  m_fault = fst;
        else                m_fault = fld;
        if (fl) m_busy = 0;
        else    m_age  = 2;
      end else begin
        if (fl || rr) m_busy = 0;
        else          m_age++;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    iv = 0; dv = 0; dwr = 0; fl = 0; rr = 1;
    fi = 0; fld = 0; fst = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
    step();
  endtask

  task automatic rnd_inputs();
    iv   = ($urandom_range(0, 2) != 0);
    dv   = ($urandom_range(0, 2) != 0);
    dwr  = $urandom_range(0, 1);
    fl   = ($urandom_range(0, 15) == 0);
    rr   = $urandom_range(0, 1);
    iadr = {$urandom, $urandom};
    dadr = {$urandom, $urandom};
    isz  = $urandom_range(0, 3);
    dsz  = $urandom_range(0, 3);
    priv = $urandom_range(0, 3);
    fi   = $urandom_range(0, 1);
    fld  = $urandom_range(0, 1);
    fst  = $urandom_range(0, 1);
  endtask

  initial begin
    reset_n = 0;
    quiet();
    iadr = '0; dadr = '0;
    isz = 0; dsz = 0; priv = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single I request, instruction fault
    iv = 1; iadr = 56'h8000_0000; isz = 2; fi = 1;
    step();
    iv = 0;
    step();
    fi = 0;
    step();
    step();

    // both valid from reset: D, I, D
    do_reset();
    gnt_q.delete();
    iv = 1; dv = 1; rr = 1;
    iadr = 56'h1000; dadr = 56'h2000;
    repeat (9) step();
    quiet();
    check("ngnt", gnt_q.size(), 3);
    if (gnt_q.size() >= 3) begin
      check("gnt0", gnt_q[0], 1);
      check("gnt1", gnt_q[1], 0);
      check("gnt2", gnt_q[2], 1);
    end

    // D store then D load
    dv = 1; dwr = 1; dadr = 56'h3000; fst = 1; fld = 0;
    step();
    dv = 0;
    step(); step(); step();
    dv = 1; dwr = 0; dadr = 56'h4000;
    step();
    dv = 0;
    step(); step(); step();

    // backpressure with pending valids
    iv = 1; fi = 1;
    step();
    iv = 0;
    step();
    rr = 0; iv = 1; dv = 1;
    repeat (5) step();
    rr = 1;
    step();
    step();
    quiet();
    repeat (3) step();

    // flush in CHECK
    iv = 1;
    step();
    iv = 0; fl = 1;
    step();
    fl = 0;
    repeat (2) step();

    // flush in RESP with RespReady
    dv = 1;
    step();
    dv = 0;
    step();
    fl = 1; rr = 1;
    step();
    fl = 0;
    step();

    // flush held in IDLE
    fl = 1; iv = 1; dv = 1;
    repeat (3) step();
    quiet();

    // privilege change after accept
    priv = 3; dv = 1; dadr = 56'h5000;
    step();
    priv = 0; dv = 0;
    step();
    step();
    step();

    // async reset in the middle of CHECK
    iv = 1;
    step();
    iv = 0;
    reset_n = 0;
    step();
    step();
    reset_n = 1;
    gnt_q.delete();
    iv = 1; dv = 1;
    step();
    quiet();
    check("rst_ngnt", gnt_q.size(), 1);
    if (gnt_q.size() >= 1)
      check("rst_gnt", gnt_q[0], 1);
    repeat (3) step();

    // randomized traffic
    repeat (800) begin
      rnd_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
